// File: rtl/cam_tx_queue.sv
// cam_tx_queue: 32-bit event FIFO feeding the camera-port nibble serializer over a wr/busy handshake; define CAM_TX_QUEUE_STATS_EN for drop/sent counters
module cam_tx_queue #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [31:0]       push_data_i,
   output logic              full_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   input  logic              clr_ovf_i,
   output logic              ser_wr_o,
   output logic [31:0]       ser_data_o,
`ifdef CAM_TX_QUEUE_STATS_EN
   input  logic              ser_busy_i,
   output logic [15:0]       drop_count_o,
   output logic [15:0]       sent_count_o
`else
   input  logic              ser_busy_i
`endif
);
   typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
   state_t            state, state_nxt;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_ok, drop, pop;
   logic [ADDR_W:0]   level_nxt;
   // accept/drop/pop decisions use registered full and level; HOLD skips busy until it is valid
   always_comb begin
      push_ok   = push_i && !full_o;
      drop      = push_i && full_o;
      pop       = state == IDLE && level_o != '0 && !ser_busy_i;
      level_nxt = level_o + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop};
      state_nxt = state == IDLE ? (pop ? HOLD : IDLE) : state == HOLD ? WAIT : (ser_busy_i ? WAIT : IDLE);
   end
   // word storage; contents survive reset
   always_ff @(posedge clk_i)
      if (push_ok) mem[wr_ptr] <= push_data_i;
   // pointers, level, flags, handshake state and registered serializer outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_o    <= '0;
         full_o     <= 1'b0;
         overflow_o <= 1'b0;
         ser_wr_o   <= 1'b0;
         ser_data_o <= 32'h0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= push_ok ? wr_ptr + ADDR_W'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
         level_o    <= level_nxt;
         full_o     <= level_nxt == (ADDR_W+1)'(DEPTH);
         overflow_o <= drop || (overflow_o && !clr_ovf_i);
         ser_wr_o   <= pop;
         ser_data_o <= pop ? mem[rd_ptr] : ser_data_o;
      end
   end
`ifdef CAM_TX_QUEUE_STATS_EN
   // saturating drop and send counters; a drop wins over a same-cycle clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_count_o <= '0;
         sent_count_o <= '0;
      end else begin
         drop_count_o <= drop ? (clr_ovf_i ? 16'd1 : (drop_count_o == 16'hFFFF ? drop_count_o : drop_count_o + 16'd1))
                              : (clr_ovf_i ? 16'd0 : drop_count_o);
         sent_count_o <= (pop && sent_count_o != 16'hFFFF) ? sent_count_o + 16'd1 : sent_count_o;
      end
   end
`endif
endmodule
